// File: rtl/bus_ram_pkg.sv
// rtl/bus_ram_pkg.sv - register map and CTRL constants shared by the bus_ram files
package bus_ram_pkg;

  // Offsets of the indirect-access registers relative to REG_BASE.
  typedef enum logic [1:0] {
    OFS_PTR_LO = 2'd0,
    OFS_PTR_HI = 2'd1,
    OFS_DATA   = 2'd2,
    OFS_CTRL   = 2'd3
  } reg_ofs_e;

  // CTRL register bit positions.
  localparam int CTRL_AUTO_INC = 0;
  localparam int CTRL_WP       = 1;

  // AUTO_INC on, write protect off.
  localparam logic [7:0] CTRL_RESET = 8'h01;

  // High byte of a pointer that has been zero-extended to 16 bits.
  function automatic logic [7:0] hi_byte(input logic [15:0] v);
    return v[15:8];
  endfunction

endpackage

// File: rtl/bus_ram_sp.sv
// rtl/bus_ram_sp.sv - single-port synchronous byte RAM, write-first, registered output
module bus_ram_sp
  import bus_ram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Array write plus registered read; a write also returns the new byte.
  // en_i low holds the last read byte so a held access keeps returning it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - byte RAM on the 8-bit tristate bus with direct window and indirect port
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         WINDOW    = 128,
  parameter int         DEPTH     = 1024,
  parameter logic [7:0] REG_BASE  = 8'hC0
) (
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [8:0] WIN_SIZE = 9'(WINDOW);

  // Elaboration-time parameter sanity.
  if (DEPTH < 256 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_ram: DEPTH must be a power of two in 256..65536");
  end
  if (WINDOW < 1 || WINDOW > DEPTH || int'(BASE_ADDR) + WINDOW > 256) begin : g_bad_window
    $error("bus_ram: WINDOW must fit both the RAM and the 8-bit address space");
  end
  if (!((int'(REG_BASE) + 3 < int'(BASE_ADDR)) ||
        (int'(REG_BASE) >= int'(BASE_ADDR) + WINDOW))) begin : g_bad_regbase
    $error("bus_ram: register block overlaps the direct window");
  end

  // Address decode. Offsets are taken with a 9-bit subtraction so an address
  // below the base wraps to a large value and simply fails the range compare.
  logic [8:0] win_ofs;
  logic [8:0] reg_ofs9;
  logic       win_hit;
  logic       reg_hit;
  logic       data_hit;
  logic       mem_hit;
  reg_ofs_e   reg_ofs;
  logic [7:0] wdata;

  assign wdata    = BUS_DATA;
  assign win_ofs  = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign reg_ofs9 = {1'b0, BUS_ADDR} - {1'b0, REG_BASE};
  assign win_hit  = win_ofs < WIN_SIZE;
  assign reg_hit  = reg_ofs9 < 9'd4;
  assign reg_ofs  = reg_ofs_e'(reg_ofs9[1:0]);
  assign data_hit = reg_hit && (reg_ofs == OFS_DATA);
  assign mem_hit  = win_hit || data_hit;

  // Architectural state.
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          prev_rd_q, prev_rd_d;
  logic          drive_en_q, drive_en_d;
  logic          sel_ram_q, sel_ram_d;
  logic [7:0]    rdata_q, rdata_d;

  logic [15:0]   ptr16;
  logic          auto_inc;
  logic          wp;
  logic          inc_en;

  assign ptr16    = 16'(ptr_q);
  assign auto_inc = ctrl_q[CTRL_AUTO_INC];
  assign wp       = ctrl_q[CTRL_WP];

  // A DATA write always advances; a DATA read advances only on the first
  // cycle of a contiguous run so a held read address increments once.
  assign inc_en = data_hit && auto_inc && (BUS_WE || !prev_rd_q);

  // RAM port: window and DATA accesses are exclusive, so one address mux.
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_en;
  logic [7:0]    ram_rdata;

  assign ram_addr = win_hit ? AW'(win_ofs[7:0]) : ptr_q;
  assign ram_we   = BUS_WE && mem_hit && !wp;
  // Continuing DATA reads leave the RAM output alone; ptr has already moved on.
  assign ram_en   = !(data_hit && !BUS_WE && prev_rd_q);

  bus_ram_sp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  // Pointer and CTRL next state: register loads first, then auto-increment.
  always_comb begin
    ptr_d  = ptr_q;
    ctrl_d = ctrl_q;
    if (reg_hit && BUS_WE) begin
      case (reg_ofs)
        OFS_PTR_LO: ptr_d  = AW'({ptr16[15:8], wdata});
        OFS_PTR_HI: ptr_d  = AW'({wdata, ptr16[7:0]});
        OFS_CTRL:   ctrl_d = wdata[1:0];
        default:    ;
      endcase
    end
    if (inc_en) begin
      ptr_d = ptr_q + AW'(1);
    end
  end

  // Register readback value, captured every cycle and used only after a register read.
  always_comb begin
    rdata_d = 8'h00;
    case (reg_ofs)
      OFS_PTR_LO: rdata_d = ptr16[7:0];
      OFS_PTR_HI: rdata_d = hi_byte(ptr16);
      OFS_CTRL:   rdata_d = {6'b0, ctrl_q};
      default:    rdata_d = 8'h00;
    endcase
  end

  assign prev_rd_d  = data_hit && !BUS_WE;
  assign drive_en_d = (win_hit || reg_hit) && !BUS_WE;
  assign sel_ram_d  = mem_hit;

  // State registers; reset releases the bus and drops any pending increment.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ptr_q      <= '0;
      ctrl_q     <= CTRL_RESET[1:0];
      prev_rd_q  <= 1'b0;
      drive_en_q <= 1'b0;
      sel_ram_q  <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      ptr_q      <= ptr_d;
      ctrl_q     <= ctrl_d;
      prev_rd_q  <= prev_rd_d;
      drive_en_q <= drive_en_d;
      sel_ram_q  <= sel_ram_d;
      rdata_q    <= rdata_d;
    end
  end

  // Tristate return: the enable comes only from a register, never from BUS_ADDR.
  assign BUS_DATA = drive_en_q ? (sel_ram_q ? ram_rdata : rdata_q) : 8'hzz;

endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - scoreboard bench for bus_ram on a pulled-up tristate bus
module tb_bus_ram;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] bus_addr = 8'h90;
  logic       bus_we = 1'b0;
  logic [7:0] tb_drv = 8'h00;
  logic       tb_drv_en = 1'b0;
  tri1  [7:0] bus_data;

  // A released bus floats high through the pull, so Z reads back as 8'hFF.
  assign bus_data = tb_drv_en ? tb_drv : 8'hzz;

  bus_ram #(
    .BASE_ADDR (8'h00),
    .WINDOW    (128),
    .DEPTH     (1024),
    .REG_BASE  (8'hC0)
  ) dut (
    .CLK      (clk),
    .RESETN   (resetn),
    .BUS_DATA (bus_data),
    .BUS_ADDR (bus_addr),
    .BUS_WE   (bus_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_rd = 1'b0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: bus=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int c, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check(e.name, bus_data, e.val);
    end
  end

  task automatic tick(input logic [7:0] a, input logic we, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus_addr  = a;
    bus_we    = we;
    tb_drv    = d;
    tb_drv_en = we;
  endtask

  task automatic idle();
    tick(8'h90, 1'b0, 8'h00);
    last_rd = 1'b0;
  endtask

  // A write right after a read waits one cycle so the read return is not fought.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    if (last_rd) idle();
    tick(a, 1'b1, d);
    last_rd = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm,
                    input bit z_now = 1'b0);
    tick(a, 1'b0, 8'h00);
    if (z_now) push(cyc, 8'hFF, {nm, "_z_now"});
    push(cyc + 1, exp, nm);
    last_rd = 1'b1;
  endtask

  initial begin
    // Reset: bus released even with a register address presented.
    bus_addr = 8'hC3;
    @(posedge clk);
    @(posedge clk);
    #1;
    push(cyc, 8'hFF, "reset_z");
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    bus_addr = 8'h90;

    rd(8'hC3, 8'h01, "ctrl_reset", 1'b1);
    rd(8'hC0, 8'h00, "ptrlo_reset");
    rd(8'hC1, 8'h00, "ptrhi_reset");

    // Direct window write/read and an unmapped address.
    wr(8'h10, 8'h5A);
    rd(8'h10, 8'h5A, "win_read");
    rd(8'h90, 8'hFF, "miss_z");

    // Indirect writes across the top of the RAM.
    wr(8'hC1, 8'h03);
    wr(8'hC0, 8'hFE);
    wr(8'hC2, 8'h11);
    wr(8'hC2, 8'h22);
    wr(8'hC2, 8'h33);
    rd(8'hC0, 8'h01, "ptrlo_wrap");
    rd(8'hC1, 8'h00, "ptrhi_wrap");
    rd(8'h00, 8'h33, "win_wrap_byte");
    wr(8'hC1, 8'h03);
    wr(8'hC0, 8'hFE);
    rd(8'hC2, 8'h11, "mem_3fe");
    rd(8'hC3, 8'h01, "ctrl_gap_a");
    rd(8'hC2, 8'h22, "mem_3ff");
    rd(8'hC1, 8'h00, "ptrhi_after_wrap");
    rd(8'hC0, 8'h00, "ptrlo_after_wrap");

    // Held DATA read returns one byte and increments once.
    wr(8'hC1, 8'h02);
    wr(8'hC0, 8'h00);
    wr(8'hC2, 8'hA1);
    wr(8'hC2, 8'hB2);
    wr(8'hC2, 8'hC3);
    wr(8'hC0, 8'h00);
    rd(8'hC2, 8'hA1, "hold_1");
    rd(8'hC2, 8'hA1, "hold_2");
    rd(8'hC2, 8'hA1, "hold_3");
    rd(8'hC3, 8'h01, "ctrl_gap_b");
    rd(8'hC2, 8'hB2, "read_after_hold");
    rd(8'hC0, 8'h02, "ptrlo_hold");
    rd(8'hC1, 8'h02, "ptrhi_hold");

    // Write protect blocks memory but not the pointer.
    wr(8'h05, 8'h44);
    wr(8'hC3, 8'h03);
    wr(8'h05, 8'h77);
    wr(8'hC2, 8'h77);
    rd(8'h05, 8'h44, "wp_window");
    rd(8'hC0, 8'h03, "wp_ptr_inc");
    rd(8'hC3, 8'h03, "ctrl_readback");
    wr(8'hC3, 8'h01);
    wr(8'hC0, 8'h02);
    rd(8'hC2, 8'hC3, "wp_data");
    wr(8'h05, 8'h77);
    rd(8'h05, 8'h77, "win_unprotected");
    wr(8'hC0, 8'h02);
    wr(8'hC2, 8'h5E);
    wr(8'hC0, 8'h02);
    rd(8'hC2, 8'h5E, "data_unprotected");

    // No auto-increment.
    wr(8'hC3, 8'h00);
    wr(8'hC0, 8'h02);
    rd(8'hC2, 8'h5E, "noinc_read");
    rd(8'hC0, 8'h02, "noinc_ptr");

    // Unimplemented CTRL and PTR_HI bits read zero.
    wr(8'hC3, 8'hFC);
    rd(8'hC3, 8'h00, "ctrl_high_bits");
    wr(8'hC1, 8'hFF);
    rd(8'hC1, 8'h03, "ptrhi_mask");

    // Reset during a DATA read return.
    wr(8'hC3, 8'h01);
    wr(8'hC1, 8'h02);
    wr(8'hC0, 8'h02);
    rd(8'hC2, 8'h5E, "pre_reset_data");
    @(posedge clk);
    #1;
    bus_addr = 8'h90;
    #5;
    resetn = 1'b0;
    #1;
    check("reset_async_z", bus_data, 8'hFF);
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    last_rd = 1'b0;
    rd(8'hC0, 8'h00, "ptrlo_post_reset");
    rd(8'hC1, 8'h00, "ptrhi_post_reset");
    rd(8'hC3, 8'h01, "ctrl_post_reset");

    idle();
    idle();
    idle();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised successor of the MCU data-RAM peripheral on the shared 8-bit tristate bus. It holds DEPTH bytes of inferred single-port synchronous RAM. The first WINDOW bytes are mapped directly into the 8-bit bus address space. The full depth is reachable through a 4-register indirect port with a 16-bit pointer, auto-increment and write protect. The block sits beside the CPU and the other bus peripherals and drives BUS_DATA only on its own read returns.

## Interface
- BASE_ADDR, 8'h00: first bus address of the direct window.
- WINDOW, 128: number of directly mapped bytes; WINDOW ≤ DEPTH and BASE_ADDR+WINDOW ≤ 256.
- DEPTH, 1024: total bytes; power of two, 256..65536. AW = clog2(DEPTH).
- REG_BASE, 8'hC0: base address of the 4 registers; must not overlap the window.
- CLK, input, 1: single clock, all logic on the rising edge.
- RESETN, input, 1: asynchronous, active-low reset.
- BUS_DATA, inout, 8: shared tristate data bus.
- BUS_ADDR, input, 8: bus address.
- BUS_WE, input, 1: write strobe, 1 cycle per write.

## Operation
- Decode:
  - win_hit = BUS_ADDR in [BASE_ADDR, BASE_ADDR+WINDOW-1].
  - reg_hit = BUS_ADDR in [REG_BASE, REG_BASE+3].
  - Any other address: no write and no drive.
- Register offsets:
  - 0 PTR_LO = ptr[7:0].
  - 1 PTR_HI = ptr[AW-1:8]; unimplemented bits are written as don't-care and read 0.
  - 2 DATA = mem[ptr].
  - 3 CTRL: bit0 AUTO_INC, bit1 WP; bits 7:2 read 0.
- RAM address mux: win_hit selects BUS_ADDR-BASE_ADDR (zero-extended to AW); DATA access selects ptr. The two are exclusive, so one port is enough.
- Write, BUS_WE=1:
  - Window hit, or DATA hit: mem write unless WP=1.
  - PTR_LO / PTR_HI / CTRL: register load. These are never blocked by WP.
- DATA write with AUTO_INC=1: ptr increments after the write, including when WP blocks the memory write.
- DATA read with AUTO_INC=1: ptr increments once per read access.
  - A read access is the first cycle of a contiguous run with BUS_WE=0 and BUS_ADDR=DATA.
  - The run is detected with a registered "prev cycle was DATA read" flag.
  - Holding the address for several cycles returns the same byte and increments once.
- Increment is ptr+1 mod DEPTH; DEPTH-1 wraps to 0.
- A PTR write in the cycle after a DATA read does not corrupt the returned byte, because the RAM address was captured in the read cycle.

## Timing
- Read latency is 1 cycle. Address valid in cycle N with BUS_WE=0 and a hit means BUS_DATA is driven for all of cycle N+1 with:
  - the RAM's registered output, or
  - the register readback captured at the N edge.
- drive_en is registered from (hit && !BUS_WE). It deasserts one cycle after the hit ends; there is no combinational path from BUS_ADDR to the tristate enable.
- Write takes effect at the edge ending cycle N. A read of the same address in cycle N+1 returns the new value.
- Reset values:
  - drive_en=0, so BUS_DATA is Z.
  - ptr=0, CTRL=8'h01, read-return register=0, prev-read flag=0.
  - RAM contents are not reset.
- Reset mid-access: the bus releases asynchronously and no pending increment survives.

## Structure
- Package bus_ram_pkg holds:
  - register offsets OFS_PTR_LO=0, OFS_PTR_HI=1, OFS_DATA=2, OFS_CTRL=3;
  - CTRL bit indices CTRL_AUTO_INC=0, CTRL_WP=1;
  - CTRL_RESET=8'h01.
- Sub-module bus_ram_sp: inferred single-port synchronous RAM (8-bit data, DEPTH, write-first, registered douta).
- Top: decode, pointer/CTRL registers, prev-read flag, return mux, tristate.

## Test plan
- Reset, then read 0x00 → BUS_DATA is Z during reset and in the cycle of the read address; defined data appears one cycle later; CTRL reads 8'h01.
- Window write of 0x5A at 0x10, then read 0x10 → 0x5A in the next cycle. Read 0x90 (outside both decodes) → BUS_DATA stays Z.
- PTR_HI=0x03, PTR_LO=0xFE, write DATA 0x11, 0x22, 0x33:
  - mem[0x3FE]=0x11 and mem[0x3FF]=0x22;
  - 0x33 lands in mem[0x000] and is visible at window address 0x00;
  - ptr reads 0x0001.
- Set PTR=0x0200, read DATA held 3 cycles, then read DATA again → the same byte for 3 cycles, then mem[0x201]; ptr=0x0202.
- CTRL=0x03 (WP, AUTO_INC), window write 0x77 at 0x05 and DATA write 0x77 → memory unchanged; ptr still increments; clearing WP restores writes.
- Assert RESETN low during a DATA read return → bus goes Z immediately; ptr=0 and CTRL=0x01 after release.
